// File: rtl/reg_scoreboard_pkg.sv
// Shared types for the register scoreboard: register index, default token
// width and the bundled query result seen by the operand stage.
package reg_scoreboard_pkg;

  localparam int SB_NREG             = 32;
  localparam int SB_TOK_W            = 32;
  localparam int SB_MAX_INFLIGHT     = 3;

  typedef logic [4:0]          reg_idx_t;
  typedef logic [SB_TOK_W-1:0] tok_t;

  // Query result for one source register at the default token width
  typedef struct packed {
    tok_t iss;
    tok_t ret;
    logic busy;
  } sb_query_t;

  // Bundle one query port's outputs (default token width)
  function automatic sb_query_t pack_query(tok_t iss, tok_t ret, logic busy);
    sb_query_t q;
    q.iss  = iss;
    q.ret  = ret;
    q.busy = busy;
    return q;
  endfunction

endpackage

// File: rtl/reg_scoreboard_query.sv
// sb_query_port: selects the issue/retire tokens of one source register,
// optionally folds in a same-cycle legal writeback (SCOREBOARD_WB_BYPASS_EN),
// and flags the register busy when the two tokens differ. x0 reads as idle.
module sb_query_port
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG  = SB_NREG,
  parameter int TOK_W = SB_TOK_W
) (
  input  reg_idx_t         ra,
  input  logic [TOK_W-1:0] iss_arr [NREG],
  input  logic [TOK_W-1:0] ret_arr [NREG],
  input  logic             byp_valid,
  input  reg_idx_t         byp_rd,
  output logic [TOK_W-1:0] iss,
  output logic [TOK_W-1:0] ret,
  output logic             busy
);

  // Index mux with x0 forced to zero tokens, plus optional writeback bypass
  always_comb begin
    iss = '0;
    ret = '0;
    if (ra != '0) begin
      iss = iss_arr[ra];
      ret = ret_arr[ra];
`ifdef SCOREBOARD_WB_BYPASS_EN
      if (byp_valid && (byp_rd == ra)) begin
        ret = ret_arr[ra] + TOK_W'(1);
      end
`endif
    end
  end

`ifndef SCOREBOARD_WB_BYPASS_EN
  // Bypass inputs are only consumed when the bypass is compiled in
  logic unused_byp;
  assign unused_byp = ^{byp_valid, byp_rd};
`endif

  // Only equality matters, so counter wrap never confuses the busy flag
  assign busy = (iss != ret);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register issue/retire token counters. A register is
// busy while its issue count differs from its retire count (modular).
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a legal writeback clear busy on
// the query ports in the same cycle instead of one cycle later.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG         = SB_NREG,
  parameter int TOK_W        = SB_TOK_W,
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  reg_idx_t         issue_rd,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  reg_idx_t         wb_rd,
  input  logic             flush,
  input  reg_idx_t         ra1,
  input  reg_idx_t         ra2,
  output logic [TOK_W-1:0] iss1,
  output logic [TOK_W-1:0] ret1,
  output logic [TOK_W-1:0] iss2,
  output logic [TOK_W-1:0] ret2,
  output logic             busy1,
  output logic             busy2,
  output logic             err
);

  localparam logic [TOK_W-1:0] MAX_TOK = TOK_W'(MAX_INFLIGHT);
  localparam logic [TOK_W-1:0] TOK_ONE = TOK_W'(1);

  logic [TOK_W-1:0] iss_q [NREG];
  logic [TOK_W-1:0] iss_d [NREG];
  logic [TOK_W-1:0] ret_q [NREG];
  logic [TOK_W-1:0] ret_d [NREG];
  logic             err_q;
  logic             err_d;

  logic [TOK_W-1:0] issue_inflight;
  logic [TOK_W-1:0] wb_inflight;
  logic             issue_fire;
  logic             wb_hit;
  logic             wb_legal;
  logic             wb_illegal;
  logic             byp_valid;

  // Outstanding-write counts for the issue and writeback targets
  always_comb begin
    issue_inflight = iss_q[issue_rd] - ret_q[issue_rd];
    wb_inflight    = iss_q[wb_rd] - ret_q[wb_rd];
    issue_ready    = (issue_rd == '0) || (issue_inflight < MAX_TOK);
    issue_fire     = issue_valid && issue_ready && (issue_rd != '0) && !flush;
    wb_hit         = wb_valid && (wb_rd != '0) && !flush;
    wb_legal       = wb_hit && (wb_inflight != '0);
    wb_illegal     = wb_hit && (wb_inflight == '0);
    byp_valid      = wb_legal;
  end

  // Next-state counters: flush retires everything, otherwise apply issue/wb
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      iss_d[r] = iss_q[r];
      ret_d[r] = ret_q[r];
      if (r != 0) begin
        if (flush) begin
          ret_d[r] = iss_q[r];
        end else begin
          if (issue_fire && (issue_rd == reg_idx_t'(r))) begin
            iss_d[r] = iss_q[r] + TOK_ONE;
          end
          if (wb_legal && (wb_rd == reg_idx_t'(r))) begin
            ret_d[r] = ret_q[r] + TOK_ONE;
          end
        end
      end else begin
        iss_d[r] = '0;
        ret_d[r] = '0;
      end
    end
    err_d = err_q | wb_illegal;
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        iss_q[r] <= '0;
        ret_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        iss_q[r] <= iss_d[r];
        ret_q[r] <= ret_d[r];
      end
      err_q <= err_d;
    end
  end

  assign err = err_q;

  sb_query_port #(
    .NREG  (NREG),
    .TOK_W (TOK_W)
  ) u_query1 (
    .ra        (ra1),
    .iss_arr   (iss_q),
    .ret_arr   (ret_q),
    .byp_valid (byp_valid),
    .byp_rd    (wb_rd),
    .iss       (iss1),
    .ret       (ret1),
    .busy      (busy1)
  );

  sb_query_port #(
    .NREG  (NREG),
    .TOK_W (TOK_W)
  ) u_query2 (
    .ra        (ra2),
    .iss_arr   (iss_q),
    .ret_arr   (ret_q),
    .byp_valid (byp_valid),
    .byp_rd    (wb_rd),
    .iss       (iss2),
    .ret       (ret2),
    .busy      (busy2)
  );

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: one default-width instance for the main
// behaviour and a 2-bit-token instance to reach counter wrap quickly.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-width instance
  logic        reset, issue_valid, wb_valid, flush;
  reg_idx_t    issue_rd, wb_rd, ra1, ra2;
  logic        issue_ready, busy1, busy2, err;
  logic [31:0] iss1, ret1, iss2, ret2;

  // Narrow-token instance for wrap
  logic        w_reset, w_issue_valid, w_wb_valid, w_flush;
  reg_idx_t    w_issue_rd, w_wb_rd, w_ra1, w_ra2;
  logic        w_issue_ready, w_busy1, w_busy2, w_err;
  logic [1:0]  w_iss1, w_ret1, w_iss2, w_ret2;

  int n_checks = 0;
  int n_errors = 0;

  reg_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .ra1(ra1), .ra2(ra2), .iss1(iss1), .ret1(ret1), .iss2(iss2), .ret2(ret2),
    .busy1(busy1), .busy2(busy2), .err(err)
  );

  reg_scoreboard #(.TOK_W(2)) dut_w (
    .clk(clk), .reset(w_reset), .issue_valid(w_issue_valid), .issue_rd(w_issue_rd),
    .issue_ready(w_issue_ready), .wb_valid(w_wb_valid), .wb_rd(w_wb_rd), .flush(w_flush),
    .ra1(w_ra1), .ra2(w_ra2), .iss1(w_iss1), .ret1(w_ret1), .iss2(w_iss2), .ret2(w_ret2),
    .busy1(w_busy1), .busy2(w_busy2), .err(w_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    issue_rd = '0; wb_rd = '0; ra1 = '0; ra2 = '0;
    w_reset = 1'b0; w_issue_valid = 1'b0; w_wb_valid = 1'b0; w_flush = 1'b0;
    w_issue_rd = '0; w_wb_rd = '0; w_ra1 = '0; w_ra2 = '0;
    tick();
    reset = 1'b1; w_reset = 1'b1;

    // Some traffic, including an illegal writeback, then reset for 2 cycles
    issue_valid = 1'b1; issue_rd = 5'd1; tick();
    issue_rd = 5'd2; tick();
    issue_rd = 5'd2; tick();
    issue_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd12; tick();
    idle();
    reset = 1'b0; tick(); tick();
    reset = 1'b1;
    ra1 = 5'd2; ra2 = 5'd1; issue_rd = 5'd2; #1;
    check("rst_iss1", iss1, 0);
    check("rst_ret1", ret1, 0);
    check("rst_busy1", busy1, 0);
    check("rst_busy2", busy2, 0);
    check("rst_err", err, 0);
    check("rst_ready", issue_ready, 1);

    // Single issue then writeback on x5
    issue_valid = 1'b1; issue_rd = 5'd5; #1;
    check("iss5_ready", issue_ready, 1);
    tick();
    idle(); ra1 = 5'd5; #1;
    check("iss5_iss1", iss1, 1);
    check("iss5_ret1", ret1, 0);
    check("iss5_busy1", busy1, 1);
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    check("wb5_same_busy1", busy1, 0);
    check("wb5_same_ret1", ret1, 1);
`else
    check("wb5_same_busy1", busy1, 1);
    check("wb5_same_ret1", ret1, 0);
`endif
    tick();
    idle(); #1;
    check("wb5_ret1", ret1, 1);
    check("wb5_busy1", busy1, 0);

    // Fill x7 to the in-flight limit
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick(); tick(); tick();
    issue_valid = 1'b0; #1;
    check("x7_full_ready", issue_ready, 0);
    issue_rd = 5'd8; #1;
    check("x8_ready", issue_ready, 1);
    issue_rd = 5'd0; #1;
    check("x0_ready", issue_ready, 1);
    issue_valid = 1'b1; issue_rd = 5'd7; tick();
    issue_valid = 1'b0; ra2 = 5'd7; #1;
    check("x7_blocked_iss2", iss2, 3);
    wb_valid = 1'b1; wb_rd = 5'd7; tick();
    idle(); issue_rd = 5'd7; #1;
    check("x7_ready_again", issue_ready, 1);
    check("x7_ret2", ret2, 1);

    // Same-cycle issue and writeback on x9 with one pending
    issue_valid = 1'b1; issue_rd = 5'd9; tick();
    wb_valid = 1'b1; wb_rd = 5'd9; tick();
    idle(); ra1 = 5'd9; #1;
    check("x9_iss1", iss1, 2);
    check("x9_ret1", ret1, 1);
    check("x9_busy1", busy1, 1);

    // Writeback with nothing pending sets sticky err
    wb_valid = 1'b1; wb_rd = 5'd3; tick();
    idle(); ra2 = 5'd3; #1;
    check("x3_iss2", iss2, 0);
    check("x3_ret2", ret2, 0);
    check("x3_err", err, 1);
    tick(); tick();
    check("x3_err_sticky", err, 1);
    ra1 = 5'd0; #1;
    check("x0_iss1", iss1, 0);
    check("x0_busy1", busy1, 0);

    // Flush wins over a same-cycle issue
    issue_valid = 1'b1; issue_rd = 5'd4; tick();
    issue_rd = 5'd6; tick();
    issue_rd = 5'd10; flush = 1'b1; tick();
    idle(); ra1 = 5'd4; ra2 = 5'd6; #1;
    check("flush_busy4", busy1, 0);
    check("flush_busy6", busy2, 0);
    check("flush_ret6", ret2, 1);
    ra1 = 5'd10; ra2 = 5'd9; #1;
    check("flush_iss10", iss1, 0);
    check("flush_busy10", busy1, 0);
    check("flush_busy9", busy2, 0);
    reset = 1'b0; tick();
    reset = 1'b1; #1;
    check("err_cleared", err, 0);

    // Wrap on the 2-bit instance: bring x11 to iss=3, ret=3
    w_ra1 = 5'd11;
    for (int i = 0; i < 3; i++) begin
      w_issue_valid = 1'b1; w_issue_rd = 5'd11; tick();
      w_issue_valid = 1'b0; w_wb_valid = 1'b1; w_wb_rd = 5'd11; tick();
      w_wb_valid = 1'b0;
    end
    #1;
    check("wrap_pre_iss", w_iss1, 3);
    check("wrap_pre_busy", w_busy1, 0);
    w_issue_valid = 1'b1; w_issue_rd = 5'd11; tick();
    w_issue_valid = 1'b0; #1;
    check("wrap_iss", w_iss1, 0);
    check("wrap_ret", w_ret1, 3);
    check("wrap_busy", w_busy1, 1);
    w_wb_valid = 1'b1; w_wb_rd = 5'd11; tick();
    w_wb_valid = 1'b0; #1;
    check("wrap_ret_after", w_ret1, 0);
    check("wrap_busy_after", w_busy1, 0);
    check("wrap_err", w_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
